// File: rtl/aes_pkg.sv
// aes_pkg: shared types and sizing for the AES SPI front end.
//   state_t      - front-end FSM states
//   READOUT_W    - cyphertext readout width (bits)
//   frame_width  - shift-frame width for a given key length: key + one block
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        RUN,
        READY,
        SHIFT_OUT
    } state_t;

    localparam int READOUT_W = 128;

    function automatic int frame_width(input int k);
        return k + READOUT_W;
    endfunction

endpackage

// File: rtl/aes_sync_edge.sv
// aes_sync_edge: two-flop synchronizer for one asynchronous input, plus
// single-cycle rise/fall pulses derived in the clk domain.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears all flops)
//   din   - asynchronous input
//   level - synchronized level
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module aes_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // meta/sync form the synchronizer; prev holds the last synchronized
    // value so edges can be seen without touching the metastable stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/aes_spi.sv
// aes_spi: SPI-style serial front end for an external AES core.
// A host shifts {key, plaintext} in MSB first on sck rises while load is high.
// Dropping load starts the core; its cyphertext is then shifted out MSB first
// on sck falls.
//   clk, reset      - system clock, asynchronous active-low reset
//   sck, sdi, load  - host serial clock, data in and frame strobe (async)
//   sdo             - serial cyphertext out
//   done            - cyphertext ready for readout
//   core_ce         - load/enable to the core (high = hold core in load)
//   key, plaintext  - operands to the core
//   core_done       - core completion flag
//   cyphertext      - core result
//   frame_err       - bad frame length (only with AES_SPI_FRAME_CHECK_EN)
// Optional feature macro: AES_SPI_FRAME_CHECK_EN enables the frame-length check.
module aes_spi
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    output logic           sdo,
    input  logic           load,
    output logic           done,
    output logic           core_ce,
    output logic [K-1:0]   key,
    output logic [127:0]   plaintext,
    input  logic           core_done,
    input  logic [127:0]   cyphertext
`ifdef AES_SPI_FRAME_CHECK_EN
    ,
    output logic           frame_err
`endif
);

    localparam int F  = frame_width(K);
    localparam int CW = $clog2(F + 1);

    state_t         state;
    logic [F-1:0]   frame;
    logic [CW-1:0]  cnt;

    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic load_lvl, load_rise, load_fall;

    aes_sync_edge u_sck (
        .clk   (clk),
        .rst_n (reset),
        .din   (sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    aes_sync_edge u_sdi (
        .clk   (clk),
        .rst_n (reset),
        .din   (sdi),
        .level (sdi_lvl),
        .rise  (sdi_rise),
        .fall  (sdi_fall)
    );

    aes_sync_edge u_load (
        .clk   (clk),
        .rst_n (reset),
        .din   (load),
        .level (load_lvl),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    // Synchronizer outputs this block has no use for
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_lvl, sdi_rise, sdi_fall, load_lvl};

    // Front-end FSM. Load edges are decoded first so that an sck edge landing
    // in the same cycle is dropped. cnt counts received bits in SHIFT_IN
    // (saturating at F) and readout falls in READY/SHIFT_OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame     <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            core_ce   <= 1'b1;
`ifdef AES_SPI_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else if (load_rise) begin
            state     <= SHIFT_IN;
            cnt       <= '0;
            done      <= 1'b0;
            core_ce   <= 1'b1;
`ifdef AES_SPI_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else if (load_fall) begin
            if (state == SHIFT_IN) begin
`ifdef AES_SPI_FRAME_CHECK_EN
                if (cnt != CW'(F)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                end else begin
                    state   <= RUN;
                    core_ce <= 1'b0;
                end
`else
                state   <= RUN;
                core_ce <= 1'b0;
`endif
            end
        end else begin
            case (state)
                SHIFT_IN: begin
                    if (sck_rise) begin
                        frame <= {frame[F-2:0], sdi_lvl};
                        if (cnt != CW'(F)) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (core_done) begin
                        frame[F-1 -: READOUT_W] <= cyphertext;
                        state <= READY;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                READY, SHIFT_OUT: begin
                    if (sck_fall) begin
                        frame <= {frame[F-2:0], 1'b0};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(READOUT_W - 1)) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end else begin
                            state <= SHIFT_OUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sdo       = (state == READY || state == SHIFT_OUT) ? frame[F-1] : 1'b0;
    assign key       = frame[F-1 -: K];
    assign plaintext = frame[READOUT_W-1:0];

endmodule

// File: tb/tb_aes_spi.sv
// tb_aes_spi: self-checking bench for aes_spi (K=128) with a stand-in AES core.
// Define AES_SPI_FRAME_CHECK_EN to exercise the frame-length check.
module tb_aes_spi;

    localparam int K = 128;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           resetN;
    logic           sck;
    logic           sdi;
    logic           load;
    logic           sdo;
    logic           done;
    logic           coreCe;
    logic [K-1:0]   key;
    logic [127:0]   plaintext;
    logic           coreDone;
    logic [127:0]   cyphertext;
`ifdef AES_SPI_FRAME_CHECK_EN
    logic           frameErr;
`endif

    int checkCount = 0;
    int failCount  = 0;
    int coreCnt;

    bit           frameBits[$];
    logic [255:0] expFrame;
    logic [127:0] gotCt;
    logic         doneBeforeLast;

    aes_spi #(.K(K)) dut (
        .clk        (clk),
        .reset      (resetN),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .load       (load),
        .done       (done),
        .core_ce    (coreCe),
        .key        (key),
        .plaintext  (plaintext),
        .core_done  (coreDone),
        .cyphertext (cyphertext)
`ifdef AES_SPI_FRAME_CHECK_EN
        ,
        .frame_err  (frameErr)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in core: known FIPS-197 vector, otherwise an arbitrary mixing function
    function automatic logic [127:0] coreModel(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) begin
            return FIPS_CT;
        end
        return (p ^ {k[63:0], k[127:64]}) + 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Core latches its operands once enabled and reports done after a fixed latency
    always @(posedge clk) begin
        if (!resetN || coreCe) begin
            coreCnt  <= 0;
            coreDone <= 1'b0;
        end else begin
            if (coreCnt == 0) begin
                cyphertext <= coreModel(key, plaintext);
            end
            if (coreCnt < 12) begin
                coreCnt <= coreCnt + 1;
            end else begin
                coreDone <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic startFrame();
        @(negedge clk);
        load = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic shiftBit(input bit b);
        sdi = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic endFrame();
        repeat (8) @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic buildRandom(input int n);
        frameBits.delete();
        for (int i = 0; i < n; i++) begin
            frameBits.push_back(bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic buildFixed(input logic [255:0] v);
        frameBits.delete();
        for (int i = 255; i >= 0; i--) begin
            frameBits.push_back(v[i]);
        end
    endtask

    // Shift the prepared bits in; the expected frame is simply the last 256 bits sent
    task automatic applyStimulus();
        int n;
        n = frameBits.size();
        if (!load) begin
            startFrame();
        end
        foreach (frameBits[i]) begin
            shiftBit(frameBits[i]);
        end
        expFrame = '0;
        for (int i = 0; i < 256; i++) begin
            if (n - 256 + i >= 0) begin
                expFrame[255 - i] = frameBits[n - 256 + i];
            end
        end
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 256'(done), 256'(1));
    endtask

    task automatic readCypher(input int n, output logic [127:0] got, output logic doneLast);
        got      = '0;
        doneLast = 1'b0;
        for (int i = 0; i < n; i++) begin
            got[127 - i] = sdo;
            if (i == n - 1) begin
                doneLast = done;
            end
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    // Full transaction: shift in, check operands, run core, read back and check
    task automatic runFrame(input string tag);
        logic [127:0] expCt;
        applyStimulus();
        checkOutput({tag, "_key"}, 256'(key), 256'(expFrame[255:128]));
        checkOutput({tag, "_pt"}, 256'(plaintext), 256'(expFrame[127:0]));
        checkOutput({tag, "_ce_shift"}, 256'(coreCe), 256'(1));
        endFrame();
        checkOutput({tag, "_ce_run"}, 256'(coreCe), 256'(0));
        waitDone({tag, "_done_up"});
        expCt = coreModel(expFrame[255:128], expFrame[127:0]);
        readCypher(128, gotCt, doneBeforeLast);
        checkOutput({tag, "_ct"}, 256'(gotCt), 256'(expCt));
        checkOutput({tag, "_done_127"}, 256'(doneBeforeLast), 256'(1));
        checkOutput({tag, "_done_fall"}, 256'(done), 256'(0));
    endtask

    initial begin
        resetN = 1'b0;
        sck    = 1'b0;
        sdi    = 1'b0;
        load   = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_done", 256'(done), 256'(0));
        checkOutput("rst_sdo", 256'(sdo), 256'(0));
        checkOutput("rst_ce", 256'(coreCe), 256'(1));
        checkOutput("rst_key", 256'(key), 256'(0));
        checkOutput("rst_pt", 256'(plaintext), 256'(0));
        resetN = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] FIPS-197 vector");
        buildFixed({FIPS_KEY, FIPS_PT});
        runFrame("fips");
        checkOutput("fips_ct_exact", 256'(gotCt), 256'(FIPS_CT));

        $display("[TB] 300-bit frame, last 256 bits win");
        buildRandom(300);
        runFrame("long300");

        for (int t = 0; t < 2; t++) begin
            $display("[TB] random frame %0d", t);
            buildRandom((t == 0) ? 256 : int'($urandom_range(257, 330)));
            runFrame("rand");
        end

        $display("[TB] reset after 100 bits");
        buildRandom(100);
        applyStimulus();
        resetN = 1'b0;
        load   = 1'b0;
        sck    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_done", 256'(done), 256'(0));
        checkOutput("midrst_ce", 256'(coreCe), 256'(1));
        checkOutput("midrst_key", 256'(key), 256'(0));
        resetN = 1'b1;
        repeat (4) @(negedge clk);
        buildRandom(256);
        runFrame("after_rst");

        $display("[TB] abort during readout");
        buildRandom(256);
        applyStimulus();
        endFrame();
        waitDone("abort_done_up");
        readCypher(40, gotCt, doneBeforeLast);
        checkOutput("abort_ct40", 256'(gotCt[127:88]),
                    256'(coreModel(expFrame[255:128], expFrame[127:0]) >> 88));
        @(negedge clk);
        load = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_done_low", 256'(done), 256'(0));
        buildRandom(256);
        runFrame("abort_new");

        $display("[TB] 200-bit short frame");
        buildRandom(200);
        applyStimulus();
        endFrame();
`ifdef AES_SPI_FRAME_CHECK_EN
        checkOutput("short_err", 256'(frameErr), 256'(1));
        checkOutput("short_ce", 256'(coreCe), 256'(1));
        repeat (200) @(negedge clk);
        checkOutput("short_no_done", 256'(done), 256'(0));
`else
        checkOutput("short_ce_run", 256'(coreCe), 256'(0));
        waitDone("short_done_up");
        readCypher(128, gotCt, doneBeforeLast);
        checkOutput("short_done_fall", 256'(done), 256'(0));
`endif

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
